// File: rtl/mem_op_sequencer_pkg.sv
// Shared types and default sizes for the memory-to-memory command engine.
//   op_t    : command opcodes as carried on cmd_op
//   state_t : engine FSM states
//   DATA_W_DFLT / ADDR_W_DFLT : default word / address widths (16 x 8 memory)
package mem_op_pkg;

  localparam int DATA_W_DFLT = 8;
  localparam int ADDR_W_DFLT = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_SUM = 2'd2,
    OP_MOV = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_ACCUM = 2'd2,
    S_WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_op_sequencer_alu.sv
// Combinational ALU used by the sequencer for both single-shot ops and the
// per-element accumulation of SUMRANGE.
//   op    : opcode (OP_SUM behaves as an add)
//   a, b  : operands
//   res   : low DATA_W bits of the result
//   carry : carry out for adds, borrow (a < b) for subtracts, 0 for moves
module mem_op_alu
  import mem_op_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT
) (
  input  op_t               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res,
  output logic              carry
);

  // One extra bit holds the carry, or the borrow in two's complement for SUB
  logic [DATA_W:0] sum_s;

  // Operation select; the top bit of the wide result is the carry/borrow flag
  always_comb begin
    sum_s = '0;
    case (op)
      OP_ADD, OP_SUM: sum_s = {1'b0, a} + {1'b0, b};
      OP_SUB:         sum_s = {1'b0, a} - {1'b0, b};
      OP_MOV:         sum_s = {1'b0, a};
      default:        sum_s = '0;
    endcase
    res   = sum_s[DATA_W-1:0];
    carry = sum_s[DATA_W];
  end

endmodule

// File: rtl/mem_op_sequencer.sv
// Command-driven execution engine in front of a 16x8 two-read/one-write memory.
// Accepts one ADD/SUB/MOV/SUMRANGE command per handshake, reads operands through
// the combinational read ports, and writes the 8-bit result to cmd_dst.
//   clk, reset          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready : command handshake (ready only while idle)
//   cmd_op/a/b/dst      : opcode, operand/range addresses, destination
//   rAddr/rData         : read port 1 (operand A / range pointer)
//   rAddr2/rData2       : read port 2 (operand B)
//   we/wAddr/wData      : memory write port, active only in WRITE
//   done/result/ovf     : completion pulse, last written value and its overflow
module mem_op_sequencer
  import mem_op_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int ADDR_W = ADDR_W_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_a,
  input  logic [ADDR_W-1:0] cmd_b,
  input  logic [ADDR_W-1:0] cmd_dst,
  output logic [ADDR_W-1:0] rAddr,
  output logic [ADDR_W-1:0] rAddr2,
  input  logic [DATA_W-1:0] rData,
  input  logic [DATA_W-1:0] rData2,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [DATA_W-1:0] wData,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  state_t              state_r;
  state_t              state_nxt_s;
  logic                accept_s;
  op_t                 op_r;
  logic [ADDR_W-1:0]   dst_r;
  logic [ADDR_W-1:0]   ptr_r;      // doubles as read port 1 address
  logic [ADDR_W-1:0]   addr_b_r;
  logic [ADDR_W-1:0]   cnt_r;      // elements remaining after the current one
  logic [DATA_W-1:0]   acc_r;
  logic                sticky_r;   // OR of all carries seen so far in SUMRANGE
  logic                ready_r;
  logic                we_r;
  logic [ADDR_W-1:0]   waddr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                done_r;
  logic [DATA_W-1:0]   result_r;
  logic                ovf_r;

  op_t                 alu_op_s;
  logic [DATA_W-1:0]   alu_a_s;
  logic [DATA_W-1:0]   alu_b_s;
  logic [DATA_W-1:0]   alu_res_s;
  logic                alu_carry_s;

  assign cmd_ready = ready_r;
  assign rAddr     = ptr_r;
  assign rAddr2    = addr_b_r;
  assign we        = we_r;
  assign wAddr     = waddr_r;
  assign wData     = wdata_r;
  assign done      = done_r;
  assign result    = result_r;
  assign ovf       = ovf_r;

  mem_op_alu #(.DATA_W(DATA_W)) u_alu (
    .op    (alu_op_s),
    .a     (alu_a_s),
    .b     (alu_b_s),
    .res   (alu_res_s),
    .carry (alu_carry_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and handshake acceptance
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (cmd_valid) begin
          accept_s = 1'b1;
          if (cmd_op == OP_SUM) begin
            state_nxt_s = S_ACCUM;
          end else begin
            state_nxt_s = S_EXEC;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_EXEC:  state_nxt_s = S_WRITE;
      S_ACCUM: begin
        if (cnt_r == '0) begin
          state_nxt_s = S_WRITE;
        end else begin
          state_nxt_s = S_ACCUM;
        end
      end
      S_WRITE: state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // ALU operand select: accumulator + current element during SUMRANGE
  always_comb begin
    if (state_r == S_ACCUM) begin
      alu_op_s = OP_ADD;
      alu_a_s  = acc_r;
      alu_b_s  = rData;
    end else begin
      alu_op_s = op_r;
      alu_a_s  = rData;
      alu_b_s  = rData2;
    end
  end

  // Datapath: operand latching, accumulation and registered write-port outputs.
  // Write outputs are loaded on the edge entering WRITE so they are valid
  // throughout the WRITE cycle and the memory captures them at its end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_r     <= OP_ADD;
      dst_r    <= '0;
      ptr_r    <= '0;
      addr_b_r <= '0;
      cnt_r    <= '0;
      acc_r    <= '0;
      sticky_r <= 1'b0;
      ready_r  <= 1'b1;
      we_r     <= 1'b0;
      waddr_r  <= '0;
      wdata_r  <= '0;
      done_r   <= 1'b0;
      result_r <= '0;
      ovf_r    <= 1'b0;
    end else begin
      ready_r <= (state_nxt_s == S_IDLE);
      we_r    <= 1'b0;
      done_r  <= 1'b0;
      wdata_r <= '0;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            op_r     <= op_t'(cmd_op);
            dst_r    <= cmd_dst;
            ptr_r    <= cmd_a;
            addr_b_r <= cmd_b;
            cnt_r    <= cmd_b - cmd_a;  // wraps mod 16, giving 1..16 elements
            acc_r    <= '0;
            sticky_r <= 1'b0;
          end
        end
        S_EXEC: begin
          we_r     <= 1'b1;
          done_r   <= 1'b1;
          waddr_r  <= dst_r;
          wdata_r  <= alu_res_s;
          result_r <= alu_res_s;
          ovf_r    <= alu_carry_s;
        end
        S_ACCUM: begin
          acc_r    <= alu_res_s;
          sticky_r <= sticky_r | alu_carry_s;
          if (cnt_r == '0) begin
            we_r     <= 1'b1;
            done_r   <= 1'b1;
            waddr_r  <= dst_r;
            wdata_r  <= alu_res_s;
            result_r <= alu_res_s;
            ovf_r    <= sticky_r | alu_carry_s;
          end else begin
            ptr_r <= ptr_r + ADDR_W'(1);
            cnt_r <= cnt_r - ADDR_W'(1);
          end
        end
        S_WRITE: begin
          we_r <= 1'b0;
        end
        default: begin
          we_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
